// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage RISC-V core.
// Drives per-stage pipeline-register enables and flushes plus the PC redirect,
// remembers a redirect that resolves while the I-cache is still fetching a
// wrong-path line, and keeps saturating stall statistics.
module hazard_ctrl #(
    parameter logic [6:0] LOAD_OP = 7'b0000011,
    parameter int         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode_EXE,
    input  logic [4:0]       write_addr_EXE,
    input  logic             RF_write_EXE,
    input  logic [4:0]       Read_addr_1_ID,
    input  logic [4:0]       Read_addr_2_ID,
    input  logic             rs2_used_ID,
    input  logic             redirect_EXE,
    input  logic [31:0]      redirect_target,
    input  logic             Icache_stall,
    input  logic             Dcache_stall,
    output logic             PC_en,
    output logic             IF_ID_en,
    output logic             ID_EXE_en,
    output logic             EXE_MEM_en,
    output logic             MEM_WB_en,
    output logic             IF_ID_flush,
    output logic             ID_EXE_flush,
    output logic             pc_redirect,
    output logic [31:0]      pc_target,
    output logic [CNT_W-1:0] istall_cnt,
    output logic [CNT_W-1:0] dstall_cnt,
    output logic [CNT_W-1:0] lu_cnt
);

    typedef enum logic {
        RUN        = 1'b0,
        REDIR_PEND = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pend_target_q, pend_target_d;
    logic [CNT_W-1:0] istall_cnt_q, istall_cnt_d;
    logic [CNT_W-1:0] dstall_cnt_q, dstall_cnt_d;
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic             lu;
    logic             lu_fire;

    // Load whose result the ID instruction needs before forwarding can supply it.
    assign lu = (opcode_EXE == LOAD_OP) && RF_write_EXE && (write_addr_EXE != 5'd0) &&
                ((write_addr_EXE == Read_addr_1_ID) ||
                 (rs2_used_ID && (write_addr_EXE == Read_addr_2_ID)));

    // The pending target is only meaningful while waiting out the I-cache miss.
    assign pc_target = (state_q == REDIR_PEND) ? pend_target_q : redirect_target;

    // Hazard priority resolution: next state and combinational stage controls.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        PC_en         = 1'b1;
        IF_ID_en      = 1'b1;
        ID_EXE_en     = 1'b1;
        EXE_MEM_en    = 1'b1;
        MEM_WB_en     = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EXE_flush  = 1'b0;
        pc_redirect   = 1'b0;
        lu_fire       = 1'b0;
        state_d       = state_q;
        pend_target_d = pend_target_q;

        if (!rst) begin
            // Hold the whole pipeline quiet and drop any pending redirect.
            PC_en         = 1'b0;
            IF_ID_en      = 1'b0;
            ID_EXE_en     = 1'b0;
            EXE_MEM_en    = 1'b0;
            MEM_WB_en     = 1'b0;
            state_d       = RUN;
            pend_target_d = '0;
        end else if (Dcache_stall) begin
            // Full freeze; a redirect in EXE is re-evaluated once MEM releases.
            PC_en      = 1'b0;
            IF_ID_en   = 1'b0;
            ID_EXE_en  = 1'b0;
            EXE_MEM_en = 1'b0;
            MEM_WB_en  = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (redirect_EXE && !Icache_stall) begin
                        pc_redirect  = 1'b1;
                        IF_ID_flush  = 1'b1;
                        ID_EXE_flush = 1'b1;
                    end else if (redirect_EXE) begin
                        // Fetch is busy on a wrong-path line; park the target.
                        PC_en         = 1'b0;
                        IF_ID_flush   = 1'b1;
                        ID_EXE_flush  = 1'b1;
                        pend_target_d = redirect_target;
                        state_d       = REDIR_PEND;
                    end else if (Icache_stall || lu) begin
                        // Front end holds, a bubble enters EXE, back end drains.
                        PC_en        = 1'b0;
                        IF_ID_en     = 1'b0;
                        ID_EXE_flush = 1'b1;
                        lu_fire      = !Icache_stall;
                    end
                end
                REDIR_PEND: begin
                    // EXE holds only bubbles here, so redirect_EXE and lu are ignored.
                    IF_ID_flush = 1'b1;
                    if (Icache_stall) begin
                        PC_en = 1'b0;
                    end else begin
                        pc_redirect = 1'b1;
                        state_d     = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Saturating next values for the stall statistics.
    always_comb begin
        istall_cnt_d = istall_cnt_q;
        dstall_cnt_d = dstall_cnt_q;
        lu_cnt_d     = lu_cnt_q;
        if (Dcache_stall && (dstall_cnt_q != '1)) begin
            dstall_cnt_d = dstall_cnt_q + CNT_W'(1);
        end
        if (Icache_stall && !Dcache_stall && (istall_cnt_q != '1)) begin
            istall_cnt_d = istall_cnt_q + CNT_W'(1);
        end
        if (lu_fire && (lu_cnt_q != '1)) begin
            lu_cnt_d = lu_cnt_q + CNT_W'(1);
        end
    end

    // State, pending target and counters, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst) begin
            // NOTE: these are plain registers, not a memory, so every one of them is reset.
            state_q       <= RUN;
            pend_target_q <= '0;
            istall_cnt_q  <= '0;
            dstall_cnt_q  <= '0;
            lu_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            pend_target_q <= pend_target_d;
            istall_cnt_q  <= istall_cnt_d;
            dstall_cnt_q  <= dstall_cnt_d;
            lu_cnt_q      <= lu_cnt_d;
        end
    end

    assign istall_cnt = istall_cnt_q;
    assign dstall_cnt = dstall_cnt_q;
    assign lu_cnt     = lu_cnt_q;

endmodule
